// File: rtl/inst_rom_pkg.sv
// Shared fetch-bus constants and loader state encoding for the instruction ROM.
package inst_rom_pkg;

  localparam int          INST_ADDR_W       = 32;        // InstAddrBus width
  localparam int          INST_W            = 32;        // InstBus width
  localparam logic [31:0] ZERO_WORD         = 32'h0;     // ZeroWord
  localparam logic        CHIP_ENABLE       = 1'b1;      // ChipEnable
  localparam logic        CHIP_DISABLE      = 1'b0;      // ChipDisable
  localparam logic        RST_ENABLE        = 1'b0;      // RstEnable (active-low reset)
  localparam int          INST_MEM_NUM      = 1024;      // InstMemNum
  localparam int          INST_MEM_NUM_LOG2 = $clog2(INST_MEM_NUM);

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_READY = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_loader.sv
// Byte-serial boot loader: assembles big-endian words and streams them into the array.
module inst_rom_loader
  import inst_rom_pkg::*;
#(
  parameter int DEPTH = INST_MEM_NUM,
  parameter int AW    = INST_MEM_NUM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start_i,
  input  logic              ld_byte_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_done_i,
  output logic              we_o,
  output logic [AW-1:0]     widx_o,
  output logic [INST_W-1:0] wdata_o,
  output logic              ready_o,
  output logic              ld_err_o
);

  // Pointer is one bit wider so it can hold DEPTH, meaning "array full".
  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

  ld_state_e   state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;   // first three bytes of the word being assembled
  logic        err_q, err_d;
  logic        ready_q, ready_d;

  // Next-state logic: ld_start restarts a load from any state and beats everything else;
  // within LOAD, ld_done beats a byte presented in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    err_d   = err_q;
    we_o    = 1'b0;
    widx_o  = ptr_q[AW-1:0];
    wdata_o = {asm_q, ld_byte_i};
    if (ld_start_i) begin
      state_d = LD_LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      asm_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LD_LOAD: begin
          if (ld_done_i) begin
            // A partial word at the end of the stream is discarded and flagged.
            if (cnt_q != 2'd0) err_d = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = LD_READY;
          end else if (ld_byte_valid_i) begin
            if (ptr_q == PTR_FULL) begin
              err_d = 1'b1;
            end else if (cnt_q == 2'd3) begin
              we_o  = 1'b1;
              ptr_d = ptr_q + 1'b1;
              cnt_d = '0;
              asm_d = '0;
            end else begin
              asm_d = {asm_q[15:0], ld_byte_i};
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == LD_READY);
  end

  // Loader state registers; the array itself lives in the top level and is never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o  = ready_q;
  assign ld_err_o = err_q;

endmodule

// File: rtl/inst_rom.sv
// Instruction memory responder: synchronous-read word array plus a LAT-deep response pipeline.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int DEPTH = INST_MEM_NUM,       // power of two
  parameter int AW    = INST_MEM_NUM_LOG2,  // log2(DEPTH)
  parameter int LAT   = 1                   // 1..3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] addr,
  output logic [INST_W-1:0]      inst,
  output logic                   inst_valid,
  output logic                   fault,
  input  logic                   ld_start,
  input  logic                   ld_byte_valid,
  input  logic [7:0]             ld_byte,
  input  logic                   ld_done,
  output logic                   ready,
  output logic                   ld_err
);

  logic              we;
  logic [AW-1:0]     widx;
  logic [INST_W-1:0] wdata;

  inst_rom_loader #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clk             (clk),
    .rst             (rst),
    .ld_start_i      (ld_start),
    .ld_byte_valid_i (ld_byte_valid),
    .ld_byte_i       (ld_byte),
    .ld_done_i       (ld_done),
    .we_o            (we),
    .widx_o          (widx),
    .wdata_o         (wdata),
    .ready_o         (ready),
    .ld_err_o        (ld_err)
  );

  logic              req_live;
  logic              req_fault;
  logic [AW-1:0]     req_idx;
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] data_q [LAT];   // stage 0 is the RAM read register
  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    flt_q;

  // Classify the incoming request: bubbles while not loaded, faults on misalignment or range.
  always_comb begin
    req_live  = (ce != CHIP_DISABLE) && ready;
    req_fault = (addr[1:0] != 2'b00) || (addr[INST_ADDR_W-1:AW+2] != '0);
    req_idx   = addr[AW+1:2];
  end

  // Array write from the loader, registered read, then LAT-1 unreset data stages.
  // Data of bubbles and faults is don't-care here; it is masked at the output.
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
    data_q[0] <= mem_q[req_idx];
    for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
  end

  // Valid/fault side-band travels alongside the data and is flushed by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      vld_q <= '0;
      flt_q <= '0;
    end else begin
      vld_q[0] <= req_live;
      flt_q[0] <= req_live && req_fault;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        flt_q[i] <= flt_q[i-1];
      end
    end
  end

  assign inst_valid = vld_q[LAT-1];
  assign fault      = flt_q[LAT-1];
  assign inst       = (vld_q[LAT-1] && !flt_q[LAT-1]) ? data_q[LAT-1] : ZERO_WORD;

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench: LAT=1 and LAT=3 instances share stimulus; a per-instance queue
// scoreboard holds the expected response of every sampled request.
module tb_inst_rom;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        ld_start = 1'b0;
  logic        ld_byte_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_done = 1'b0;

  logic [31:0] inst1, inst3;
  logic        v1, v3, f1, f3, rdy1, rdy3, err1, err3;

  always #5 clk = ~clk;

  inst_rom #(.DEPTH(DEPTH), .AW(10), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst1), .inst_valid(v1), .fault(f1),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_done(ld_done),
    .ready(rdy1), .ld_err(err1)
  );

  inst_rom #(.DEPTH(DEPTH), .AW(10), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst3), .inst_valid(v3), .fault(f3),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte), .ld_done(ld_done),
    .ready(rdy3), .ld_err(err3)
  );

  typedef struct {
    logic        v;
    logic        f;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    exp_t        e;
  } vec_t;

  exp_t q1[$];
  exp_t q3[$];

  // Behavioural model of the loader (0 idle, 1 load, 2 ready) and of the array contents.
  int          m_state = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [31:0] m_asm = 32'h0;
  logic        m_err = 1'b0;
  logic [31:0] m_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t model_exp(input logic c, input logic [31:0] a);
    exp_t e;
    e.v = 1'b0;
    e.f = 1'b0;
    e.d = 32'h0;
    if (c && m_state == 2) begin
      e.v = 1'b1;
      if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) e.f = 1'b1;
      else e.d = m_mem[a[11:2]];
    end
    return e;
  endfunction

  task automatic model_edge();
    if (ld_start) begin
      m_state = 1; m_ptr = 0; m_cnt = 0; m_asm = 32'h0; m_err = 1'b0;
    end else if (m_state == 1) begin
      if (ld_done) begin
        if (m_cnt != 0) m_err = 1'b1;
        m_cnt = 0;
        m_state = 2;
      end else if (ld_byte_valid) begin
        if (m_ptr == DEPTH) m_err = 1'b1;
        else begin
          m_asm = {m_asm[23:0], ld_byte};
          m_cnt++;
          if (m_cnt == 4) begin
            m_mem[m_ptr] = m_asm;
            m_ptr++;
            m_cnt = 0;
          end
        end
      end
    end
  endtask

  task automatic cmp_resp(input string tag, input exp_t x, input logic v, input logic f,
                          input logic [31:0] d);
    chk({tag, "_valid"}, v, x.v);
    chk({tag, "_fault"}, f, x.f);
    chk({tag, "_inst"}, d, x.d);
    if (x.v) $display("%s response inst=%h valid=%b fault=%b", tag, d, v, f);
  endtask

  // One clock: record the expected response of the request sampled at this edge,
  // advance the loader model, then compare whatever each instance is presenting.
  task automatic step(input exp_t e);
    exp_t x;
    @(posedge clk);
    q1.push_back(e);
    q3.push_back(e);
    model_edge();
    #1;
    if (q1.size() == 1) begin
      x = q1.pop_front();
      cmp_resp("lat1", x, v1, f1, inst1);
    end
    if (q3.size() == 3) begin
      x = q3.pop_front();
      cmp_resp("lat3", x, v3, f3, inst3);
    end
    chk("ready_lat1", rdy1, m_state == 2);
    chk("ready_lat3", rdy3, m_state == 2);
    chk("ld_err_lat1", err1, m_err);
    chk("ld_err_lat3", err3, m_err);
  endtask

  task automatic fetch(input logic c, input logic [31:0] a);
    ce = c;
    addr = a;
    step(model_exp(c, a));
    ce = 1'b0;
  endtask

  task automatic do_start();
    ld_start = 1'b1;
    step(model_exp(ce, addr));
    ld_start = 1'b0;
  endtask

  task automatic do_byte(input logic [7:0] b);
    ld_byte_valid = 1'b1;
    ld_byte = b;
    step(model_exp(ce, addr));
    ld_byte_valid = 1'b0;
  endtask

  task automatic do_done();
    ld_done = 1'b1;
    step(model_exp(ce, addr));
    ld_done = 1'b0;
  endtask

  task automatic do_word(input logic [31:0] w);
    do_byte(w[31:24]);
    do_byte(w[23:16]);
    do_byte(w[15:8]);
    do_byte(w[7:0]);
  endtask

  // Assert reset between edges and check everything drops before the next edge.
  task automatic do_reset_mid();
    #2 rst = 1'b0;
    #1;
    chk("rst_inst_lat1", inst1, 32'h0);
    chk("rst_inst_lat3", inst3, 32'h0);
    chk("rst_valid_lat1", v1, 1'b0);
    chk("rst_valid_lat3", v3, 1'b0);
    chk("rst_fault_lat1", f1, 1'b0);
    chk("rst_fault_lat3", f3, 1'b0);
    chk("rst_ready_lat1", rdy1, 1'b0);
    chk("rst_ready_lat3", rdy3, 1'b0);
    chk("rst_ld_err_lat1", err1, 1'b0);
    chk("rst_ld_err_lat3", err3, 1'b0);
    q1.delete();
    q3.delete();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_asm = 32'h0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    // Fetch vectors applied back-to-back once words 0/1 hold 34020001/20420003.
    vecs[0] = '{1'b1, 32'h0000_0000, '{1'b1, 1'b0, 32'h3402_0001}};
    vecs[1] = '{1'b1, 32'h0000_0004, '{1'b1, 1'b0, 32'h2042_0003}};
    vecs[2] = '{1'b1, 32'h0000_0000, '{1'b1, 1'b0, 32'h3402_0001}};
    vecs[3] = '{1'b1, 32'h0000_0002, '{1'b1, 1'b1, 32'h0000_0000}};
    vecs[4] = '{1'b1, 32'h0000_1000, '{1'b1, 1'b1, 32'h0000_0000}};
    vecs[5] = '{1'b0, 32'h0000_0000, '{1'b0, 1'b0, 32'h0000_0000}};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, '{1'b1, 1'b1, 32'h0000_0000}};
    vecs[7] = '{1'b1, 32'h0000_0004, '{1'b1, 1'b0, 32'h2042_0003}};
    vecs[8] = '{1'b1, 32'h0000_0001, '{1'b1, 1'b1, 32'h0000_0000}};
    vecs[9] = '{1'b0, 32'h0000_0004, '{1'b0, 1'b0, 32'h0000_0000}};

    // Reset state.
    #12;
    chk("init_inst_lat1", inst1, 32'h0);
    chk("init_inst_lat3", inst3, 32'h0);
    chk("init_valid_lat1", v1, 1'b0);
    chk("init_valid_lat3", v3, 1'b0);
    chk("init_ready_lat1", rdy1, 1'b0);
    chk("init_ld_err_lat3", err3, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Fetches before any load are bubbles.
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h0);

    // First load: two words.
    do_start();
    do_word(32'h3402_0001);
    do_word(32'h2042_0003);
    do_done();

    // Table-driven fetches.
    for (int i = 0; i < 10; i++) begin
      ce = vecs[i].ce;
      addr = vecs[i].addr;
      step(vecs[i].e);
    end
    for (int i = 0; i < 3; i++) fetch(1'b0, 32'h0);

    // READY->LOAD: request sampled with ld_start completes, the next one is a bubble.
    ce = 1'b1;
    addr = 32'h0;
    ld_start = 1'b1;
    step(model_exp(1'b1, 32'h0));
    ld_start = 1'b0;
    fetch(1'b1, 32'h0);

    // Six bytes: word 0 rewritten, partial word dropped, ld_err set.
    do_word(32'hAABB_CCDD);
    do_byte(8'h11);
    do_byte(8'h22);
    do_done();
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);
    for (int i = 0; i < 3; i++) fetch(1'b0, 32'h0);

    // Reset while READY with ld_err set, then fetch is a bubble.
    do_reset_mid();
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h0);

    // Reset in the middle of a load.
    do_start();
    do_byte(8'h99);
    do_byte(8'h88);
    do_reset_mid();
    fetch(1'b1, 32'h0);

    // Raise ld_err, then a following ld_start clears it; empty reload keeps word 0.
    do_start();
    do_byte(8'h55);
    do_done();
    do_start();
    do_done();
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h4);
    for (int i = 0; i < 3; i++) fetch(1'b0, 32'h0);

    // Full load to DEPTH words; a byte presented with ld_start is dropped,
    // and one byte past the end sets ld_err while still loading.
    ld_byte_valid = 1'b1;
    ld_byte = 8'h77;
    do_start();
    for (int w = 0; w < DEPTH; w++) do_word({16'hC0DE ^ 16'(w), 16'(w)});
    do_byte(8'h5A);
    do_done();
    fetch(1'b1, 32'h0000_0000);
    fetch(1'b1, 32'h0000_0004);
    fetch(1'b1, 32'h0000_0FFC);
    fetch(1'b1, 32'h0000_1000);
    for (int i = 0; i < 3; i++) fetch(1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
